// File: rtl/mux64_rr_arbiter_pkg.sv
// Shared constants, FSM state encoding and a constant clog2 helper for the
// 64-way round-robin mux select arbiter.
package mux_arb_pkg;

    localparam int N     = 64;
    localparam int SEL_W = 6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux64_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N     = mux_arb_pkg::N,
    parameter int SEL_W = mux_arb_pkg::SEL_W
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [N-1:0]     rot;
    logic [SEL_W-1:0] first;

    // rot[i] is the requester i positions above ptr; the SEL_W-wide index
    // sum wraps modulo N because N is a power of two.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[SEL_W'(i) + ptr];
        end
    end

    always_comb begin
        first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) first = SEL_W'(i);
        end
    end

    assign any = |req;
    assign idx = first + ptr;

endmodule

// File: rtl/mux64_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 64:1 mux; holds a grant
// until release, request drop, or MAX_HOLD expiry, with one idle bubble after.
module mux64_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N        = mux_arb_pkg::N,
    parameter int SEL_W    = mux_arb_pkg::SEL_W,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             release_i,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic             timeout
);

    localparam int HOLD_W = clog2(MAX_HOLD + 1);

    arb_state_t        state;
    logic [SEL_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;
    logic [N-1:0]      pick_onehot;
    logic              owner_req;
    logic              expired;
    logic              rel;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;
    assign owner_req   = req[sel];
    assign expired     = (hold_cnt == HOLD_W'(MAX_HOLD));
    assign rel         = release_i | ~owner_req | expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sel         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            ptr         <= '0;
            hold_cnt    <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        sel         <= pick_idx;
                        grant       <= pick_onehot;
                        grant_valid <= 1'b1;
                        hold_cnt    <= HOLD_W'(1);
                        state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (rel) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= sel + SEL_W'(1);
                        hold_cnt    <= '0;
                        state       <= ST_IDLE;
                        // Only a pure expiry is a timeout; an explicit or implicit
                        // release in the same cycle takes precedence.
                        timeout     <= expired & ~release_i & owner_req;
                    end else if (!expired) begin
                        hold_cnt    <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
